// File: rtl/alu_regfile_ctrl_if.sv
// Instruction issue channel between a sequencer and the register-file/issue controller.
// The sequencer drives the instruction fields and valid; the controller returns ready.
interface alu_regfile_ctrl_if;
    localparam int unsigned DW  = 16;
    localparam int unsigned AW  = 3;
    localparam int unsigned OPW = 4;

    logic           instr_valid;
    logic           instr_ready;
    logic [OPW-1:0] instr_op;
    logic [AW-1:0]  instr_rd;
    logic [AW-1:0]  instr_rs;
    logic [AW-1:0]  instr_rt;
    logic [DW-1:0]  instr_imm;

    modport master (
        output instr_valid, instr_op, instr_rd, instr_rs, instr_rt, instr_imm,
        input  instr_ready
    );

    modport slave (
        input  instr_valid, instr_op, instr_rd, instr_rs, instr_rt, instr_imm,
        output instr_ready
    );
endinterface

// File: rtl/alu_regfile_ctrl.sv
// Register file and single-issue controller wrapped around a 16-bit ALU.
// Each legal instruction takes IDLE -> EXEC -> WB; illegal opcodes pulse 'illegal' and stay in IDLE.
module alu_regfile_ctrl #(
    parameter int unsigned NREGS = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    alu_regfile_ctrl_if.slave       ibus,
    output logic [15:0]             alu_a,
    output logic [15:0]             alu_b,
    output logic [3:0]              alu_ctrl,
    input  logic [15:0]             alu_s,
    input  logic                    alu_overflow,
    input  logic                    alu_zero,
    output logic                    wb_valid,
    output logic [2:0]              wb_rd,
    output logic [15:0]             wb_data,
    output logic                    flag_z,
    output logic                    flag_v,
    output logic                    illegal,
    input  logic [2:0]              dbg_addr,
    output logic [15:0]             dbg_data
);

    localparam int unsigned DW  = 16;
    localparam int unsigned AW  = 3;
    localparam int unsigned OPW = 4;

    localparam logic [OPW-1:0] OP_ALU_MAX = OPW'(11);
    localparam logic [OPW-1:0] OP_LI      = OPW'(12);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t          state;
    logic [DW-1:0]   regs [NREGS];
    logic [OPW-1:0]  op_q;
    logic [AW-1:0]   rd_q;
    logic [DW-1:0]   res_q;
    logic            z_q;
    logic            v_q;

    // R0 is hardwired to zero on every read port.
    function automatic logic [DW-1:0] rf_read(input logic [AW-1:0] addr);
        logic [DW-1:0] val;
        val = '0;
        if (addr != '0) begin
            val = regs[addr];
        end
        return val;
    endfunction

    assign ibus.instr_ready = (state == IDLE) && !rst;
    assign dbg_data         = rf_read(dbg_addr);
    assign wb_rd            = rd_q;
    assign wb_data          = res_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            op_q     <= '0;
            rd_q     <= '0;
            res_q    <= '0;
            z_q      <= 1'b0;
            v_q      <= 1'b0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_ctrl <= '0;
            wb_valid <= 1'b0;
            flag_z   <= 1'b0;
            flag_v   <= 1'b0;
            illegal  <= 1'b0;
            for (int i = 0; i < int'(NREGS); i++) begin
                regs[i] <= '0;
            end
        end else begin
            illegal <= 1'b0;
            case (state)
                IDLE: begin
                    if (ibus.instr_valid) begin
                        if (ibus.instr_op <= OP_ALU_MAX) begin
                            op_q     <= ibus.instr_op;
                            rd_q     <= ibus.instr_rd;
                            alu_a    <= rf_read(ibus.instr_rs);
                            alu_b    <= rf_read(ibus.instr_rt);
                            alu_ctrl <= ibus.instr_op;
                            state    <= EXEC;
                        end else if (ibus.instr_op == OP_LI) begin
                            // LI reuses the operand register as the immediate carrier; ALU opcode is left untouched.
                            op_q  <= ibus.instr_op;
                            rd_q  <= ibus.instr_rd;
                            alu_a <= ibus.instr_imm;
                            alu_b <= '0;
                            state <= EXEC;
                        end else begin
                            illegal <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    if (op_q == OP_LI) begin
                        res_q <= alu_a;
                        v_q   <= 1'b0;
                        z_q   <= (alu_a == '0);
                    end else begin
                        res_q <= alu_s;
                        v_q   <= alu_overflow;
                        z_q   <= alu_zero;
                    end
                    wb_valid <= 1'b1;
                    state    <= WB;
                end
                WB: begin
                    // Flags update even for R0 so it can act as a compare-only destination.
                    if (rd_q != '0) begin
                        regs[rd_q] <= res_q;
                    end
                    flag_z   <= z_q;
                    flag_v   <= v_q;
                    wb_valid <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    wb_valid <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
